// File: rtl/float_pkg.sv
// Shared operand-format helpers for the float compare arbiter and its comparator.
// Latency: none (types, constants and functions only).
// Backpressure: none (no datapath in this file).
package float_pkg;

  // Default field widths of the sign-magnitude operand: {sign, exponent, mantissa}
  localparam int DEF_EXPONENT = 6;
  localparam int DEF_MANTISSA = 11;

  // Total operand width: one sign bit plus the exponent and mantissa fields
  function automatic int operand_width(input int exponent, input int mantissa);
    return exponent + mantissa + 1;
  endfunction

endpackage

// File: rtl/compare_float.sv
// Sign-magnitude "X greater than Y" comparator shared by all requesters.
// Latency: purely combinational, result is registered by the arbiter.
// Backpressure: none, evaluates whatever operands are muxed in each cycle.
module compare_float
  import float_pkg::*;
#(
  parameter int EXPONENT = DEF_EXPONENT,
  parameter int MANTISSA = DEF_MANTISSA
) (
  input  logic [operand_width(EXPONENT, MANTISSA)-1:0] x,
  input  logic [operand_width(EXPONENT, MANTISSA)-1:0] y,
  output logic                                         gt
);

  localparam int W = operand_width(EXPONENT, MANTISSA);

  logic         sign_x;
  logic         sign_y;
  logic [W-2:0] mag_x;
  logic [W-2:0] mag_y;
  logic         mag_gt;
  logic         both_zero;

  assign sign_x    = x[W-1];
  assign sign_y    = y[W-1];
  assign mag_x     = x[W-2:0];
  assign mag_y     = y[W-2:0];
  assign mag_gt    = (mag_x > mag_y);
  // Only the all-zero-bits pair is special-cased; +0 vs -0 is ordered by sign
  assign both_zero = (x == '0) && (y == '0);

  // Order by sign first; for two negatives the magnitude order is inverted,
  // which deliberately makes equal negatives report "greater".
  always_comb begin
    gt = 1'b0;
    if (!both_zero) begin
      case ({sign_x, sign_y})
        2'b00:   gt = mag_gt;
        2'b01:   gt = 1'b1;
        2'b10:   gt = 1'b0;
        default: gt = !mag_gt;
      endcase
    end
  end

endmodule

// File: rtl/float_compare_arbiter.sv
// Round-robin arbiter sharing one float comparator among NUM_REQ requesters (optional stats: FLOAT_COMPARE_ARBITER_STATS_EN).
// Latency: grant in cycle N, registered rsp_valid/rsp_id/rsp_gt visible in cycle N+1.
// Backpressure: single output slot; no grant while the slot is held, refill in the same cycle it drains.
module float_compare_arbiter
  import float_pkg::*;
#(
  parameter int EXPONENT = DEF_EXPONENT,
  parameter int MANTISSA = DEF_MANTISSA,
  parameter int NUM_REQ  = 4
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic [NUM_REQ-1:0]                                   req_valid,
  output logic [NUM_REQ-1:0]                                   req_ready,
  input  logic [NUM_REQ*operand_width(EXPONENT, MANTISSA)-1:0] req_x,
  input  logic [NUM_REQ*operand_width(EXPONENT, MANTISSA)-1:0] req_y,
  output logic                                                 rsp_valid,
  input  logic                                                 rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                           rsp_id,
  output logic                                                 rsp_gt
`ifdef FLOAT_COMPARE_ARBITER_STATS_EN
  ,
  output logic [15:0]                                          cmp_count
`endif
);

  localparam int W  = operand_width(EXPONENT, MANTISSA);
  localparam int IW = $clog2(NUM_REQ);

  // Round-robin pointer type is private to the arbiter
  typedef logic [IW-1:0] ptr_t;

  ptr_t         ptr;
  ptr_t         gnt_idx;
  ptr_t         ptr_nxt;
  logic         found;
  logic         can_accept;
  logic         grant;
  logic [W-1:0] mux_x;
  logic [W-1:0] mux_y;
  logic         cmp_gt;
  int           search_idx;

  // Slot can take a new result when empty or when it drains this cycle
  assign can_accept = !rsp_valid || rsp_ready;

  // Search requesters starting at ptr, wrapping; first valid one wins
  always_comb begin
    found      = 1'b0;
    gnt_idx    = '0;
    search_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = int'(ptr) + k;
      if (search_idx >= NUM_REQ) begin
        search_idx = search_idx - NUM_REQ;
      end
      if (!found && req_valid[ptr_t'(search_idx)]) begin
        found   = 1'b1;
        gnt_idx = ptr_t'(search_idx);
      end
    end
  end

  // Reset gates the grant so req_ready stays low for the whole reset pulse
  assign grant = found && can_accept && reset_n;

  // One-hot accept towards the winning requester, zero otherwise
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Steer the winner's operands into the shared comparator
  always_comb begin
    mux_x = '0;
    mux_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ptr_t'(i)) begin
        mux_x = req_x[i*W +: W];
        mux_y = req_y[i*W +: W];
      end
    end
  end

  // Pointer moves just past the granted index, wrapping at NUM_REQ
  assign ptr_nxt = (gnt_idx == ptr_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  compare_float #(
    .EXPONENT(EXPONENT),
    .MANTISSA(MANTISSA)
  ) u_compare_float (
    .x (mux_x),
    .y (mux_y),
    .gt(cmp_gt)
  );

  // Output slot: load on grant, drain on consume, id/gt held otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      ptr       <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_gt    <= cmp_gt;
      ptr       <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef FLOAT_COMPARE_ARBITER_STATS_EN
  // Grant counter that sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_count <= '0;
    end else if (grant && (cmp_count != 16'hFFFF)) begin
      cmp_count <= cmp_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_float_compare_arbiter.sv
// Self-checking bench for float_compare_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the round-robin slot and the sign-magnitude compare rule.
// Covers the grant counter too when FLOAT_COMPARE_ARBITER_STATS_EN is defined.
module tb_float_compare_arbiter;

  localparam int N  = 4;
  localparam int W  = 18;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_x = '0;
  logic [N*W-1:0]  req_y = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic            rsp_gt;
`ifdef FLOAT_COMPARE_ARBITER_STATS_EN
  logic [15:0]     cmp_count;
`endif

  int checks = 0;
  int passed = 0;

  float_compare_arbiter #(
    .EXPONENT(6),
    .MANTISSA(11),
    .NUM_REQ (N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_gt   (rsp_gt)
`ifdef FLOAT_COMPARE_ARBITER_STATS_EN
    ,
    .cmp_count(cmp_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference compare: decide by signs, then by integer magnitude
  function automatic bit ref_gt(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned mx;
    int unsigned my;
    if (x == 0 && y == 0) return 1'b0;
    mx = int'(x[W-2:0]);
    my = int'(y[W-2:0]);
    if (!x[W-1] && !y[W-1]) return mx > my;
    if (!x[W-1] &&  y[W-1]) return 1'b1;
    if ( x[W-1] && !y[W-1]) return 1'b0;
    return !(mx > my);
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", rsp_id); else passed++;
    checks++; if (rsp_gt !== 1'b0) $display("FAIL reset_rsp_gt got %b want 0", rsp_gt); else passed++;
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", req_ready); else passed++;
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    set_op(0, 18'h00C00, 18'h00A00);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL single_rsp_id got %0d want 0", rsp_id); else passed++;
    checks++; if (rsp_gt !== 1'b1) $display("FAIL single_rsp_gt got %b want 1", rsp_gt); else passed++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    apply_reset();
    for (int i = 0; i < N; i++) set_op(i, 18'(i * 1000), 18'(500));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      want = 4'(1 << (c % N));
      #1;
      checks++; if (req_ready !== want) $display("FAIL rr_ready cycle %0d got %b want %b", c, req_ready, want); else passed++;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % N))
        $display("FAIL rr_rsp cycle %0d got valid %b id %0d want valid 1 id %0d", c, rsp_valid, rsp_id, c % N);
      else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_op(2, 18'h00C00, 18'h00A00);
    set_op(3, 18'h00A00, 18'h00C00);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL bp_first_ready got %b want 0100", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) $display("FAIL bp_stall_ready cycle %0d got %b want 0000", c, req_ready); else passed++;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_gt !== 1'b1)
        $display("FAIL bp_frozen cycle %0d got valid %b id %0d gt %b want 1 2 1", c, rsp_valid, rsp_id, rsp_gt);
      else passed++;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL bp_release_ready got %b want 1000", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (rsp_id !== 2'd3 || rsp_gt !== 1'b0) $display("FAIL bp_release_rsp got id %0d gt %b want 3 0", rsp_id, rsp_gt); else passed++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd3) $display("FAIL idle_drain got valid %b id %0d want 0 3", rsp_valid, rsp_id); else passed++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_gt !== 1'b0) $display("FAIL idle_hold got valid %b gt %b want 0 0", rsp_valid, rsp_gt); else passed++;
  endtask

  task automatic test_sign_cases();
    logic [W-1:0] xs [5];
    logic [W-1:0] ys [5];
    bit           want [5];
    xs[0] = 18'h00000; ys[0] = 18'h00000; want[0] = 1'b0;
    xs[1] = 18'h00000; ys[1] = 18'h20000; want[1] = 1'b1;
    xs[2] = 18'h2F800; ys[2] = 18'h0F800; want[2] = 1'b0;
    xs[3] = 18'h30000; ys[3] = 18'h2F800; want[3] = 1'b0;
    xs[4] = 18'h2F800; ys[4] = 18'h30000; want[4] = 1'b1;
    apply_reset();
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_op(0, xs[c], ys[c]);
      @(posedge clk); #1;
      checks++; if (rsp_gt !== want[c]) $display("FAIL sign_case %0d got %b want %b", c, rsp_gt, want[c]); else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_op(0, 18'h00C00, 18'h00A00);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_gt !== 1'b0)
      $display("FAIL mid_reset_outputs got valid %b id %0d gt %b want 0 0 0", rsp_valid, rsp_id, rsp_gt);
    else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL mid_reset_ready got %b want 0000", req_ready); else passed++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL post_reset_ready got %b want 0001", req_ready); else passed++;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_gt !== 1'b1)
      $display("FAIL post_reset_rsp got valid %b id %0d gt %b want 1 0 1", rsp_valid, rsp_id, rsp_gt);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];
    logic [N-1:0] want_rdy;
    int           m_ptr;
    bit           m_valid;
    int           m_id;
    bit           m_gt;
    int           win;
    int           idx;
    apply_reset();
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_gt = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = W'($urandom);
        case ($urandom_range(0, 3))
          0: ys[i] = xs[i];
          1: ys[i] = xs[i] ^ 18'h20000;
          2: begin xs[i] = '0; ys[i] = W'($urandom_range(0, 1)) << (W - 1); end
          default: ys[i] = W'($urandom);
        endcase
        set_op(i, xs[i], ys[i]);
      end
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      win = -1;
      if (!m_valid || rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      want_rdy = (win >= 0) ? N'(1 << win) : '0;
      #1;
      checks++; if (req_ready !== want_rdy) $display("FAIL rand_ready cycle %0d got %b want %b", c, req_ready, want_rdy); else passed++;
      @(posedge clk); #1;
      if (win >= 0) begin
        m_valid = 1'b1;
        m_id    = win;
        m_gt    = ref_gt(xs[win], ys[win]);
        m_ptr   = (win + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      checks++; if (rsp_valid !== m_valid) $display("FAIL rand_valid cycle %0d got %b want %b", c, rsp_valid, m_valid); else passed++;
      checks++; if (rsp_id !== 2'(m_id)) $display("FAIL rand_id cycle %0d got %0d want %0d", c, rsp_id, m_id); else passed++;
      checks++; if (rsp_gt !== m_gt) $display("FAIL rand_gt cycle %0d got %b want %b", c, rsp_gt, m_gt); else passed++;
    end
    req_valid = '0;
  endtask

`ifdef FLOAT_COMPARE_ARBITER_STATS_EN
  task automatic test_stats();
    apply_reset();
    #1;
    checks++; if (cmp_count !== 16'd0) $display("FAIL stats_reset got %h want 0000", cmp_count); else passed++;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmp_count !== 16'd3) $display("FAIL stats_three got %h want 0003", cmp_count); else passed++;
    repeat (69997) @(posedge clk);
    #1;
    checks++; if (cmp_count !== 16'hFFFF) $display("FAIL stats_saturate got %h want ffff", cmp_count); else passed++;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cmp_count !== 16'hFFFF) $display("FAIL stats_hold got %h want ffff", cmp_count); else passed++;
    req_valid = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sign_cases();
    test_reset_mid();
    test_random();
`ifdef FLOAT_COMPARE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
